// File: rtl/gpu_pkg.sv
// ============================================================================
// Module      : gpu_pkg
// Description : Shared constants for the text-RAM engine: screen geometry,
//               command opcodes and the blit controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_pkg;

  // Text screen geometry (80x30 characters, one byte per cell)
  localparam int TXT_COLS  = 80;
  localparam int TXT_ROWS  = 30;
  localparam int TXT_DEPTH = TXT_COLS * TXT_ROWS;
  localparam int TXT_AW    = 12;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_CLEAR   = 2'd1;
  localparam logic [1:0] OP_SCROLL  = 2'd2;
  localparam logic [1:0] OP_FILLROW = 2'd3;

  // Blit controller states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COPY  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/vram_blit_ctrl.sv
// ============================================================================
// Module      : vram_blit_ctrl
// Description : Text-RAM engine running clear-screen, scroll-up and fill-row
//               commands. It borrows the RAM read port only while the display
//               is in blanking (window_open) and otherwise forwards the
//               display read request untouched. The write port is engine-only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_blit_ctrl
  import gpu_pkg::*;
#(
  parameter int COLS  = TXT_COLS,
  parameter int ROWS  = TXT_ROWS,
  parameter int DEPTH = TXT_DEPTH,
  parameter int AW    = TXT_AW
) (
  input  logic          vgaClk,
  input  logic          rst,
  // command interface (already in the vgaClk domain)
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [4:0]    cmd_row,
  input  logic [7:0]    cmd_char,
  output logic          cmd_ready,
  // display side of the read port
  input  logic          window_open,
  input  logic          disp_r_en,
  input  logic [AW-1:0] disp_r_addr,
  // text RAM ports
  output logic          ram_r_en,
  output logic [AW-1:0] ram_r_addr,
  input  logic [7:0]    ram_r_data,
  output logic          ram_w_en,
  output logic [AW-1:0] ram_w_addr,
  output logic [7:0]    ram_w_data,
  // status
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Address constants sized to the RAM address bus
  localparam logic [AW-1:0] ADDR_LAST      = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_COLS      = AW'(COLS);
  localparam logic [AW-1:0] ADDR_LAST_ROW  = AW'(DEPTH - COLS);
  localparam logic [AW-1:0] ADDR_ROW_SPAN  = AW'(COLS - 1);
  localparam logic [4:0]    ROW_LIMIT      = 5'(ROWS);

  // Row base address. The shift-add is row*64 + row*16, i.e. row*80, which
  // matches the 80-column screen and avoids a multiplier.
  function automatic logic [AW-1:0] row_base(input logic [4:0] row);
    logic [AW-1:0] r;
    r = AW'(row);
    row_base = (r << 6) + (r << 4);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] src_q,   src_d;     // next copy source address
  logic [AW-1:0] ptr_q,   ptr_d;     // next fill address
  logic [AW-1:0] end_q,   end_d;     // last fill address (inclusive)
  logic [AW-1:0] waddr_q, waddr_d;   // destination of the read in flight
  logic          pend_q,  pend_d;    // a copy read was issued last cycle
  logic [7:0]    char_q,  char_d;    // latched fill character
  logic          err_q,   err_d;

  logic grant;
  logic accept;
  logic fillrow_ok;

  // The engine owns the read port only while copying and the display is idle
  assign grant      = (state_q == ST_COPY) && window_open;
  assign accept     = cmd_valid && (state_q == ST_IDLE);
  assign fillrow_ok = (cmd_row < ROW_LIMIT);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    waddr_d = waddr_q;
    pend_d  = 1'b0;
    char_d  = char_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          char_d = cmd_char;
          case (cmd_op)
            OP_NOP: begin
              state_d = ST_DONE;
            end
            OP_CLEAR: begin
              ptr_d   = '0;
              end_d   = ADDR_LAST;
              state_d = ST_FILL;
            end
            OP_SCROLL: begin
              src_d   = ADDR_COLS;
              state_d = ST_COPY;
            end
            default: begin // OP_FILLROW
              if (fillrow_ok) begin
                ptr_d   = row_base(cmd_row);
                end_d   = row_base(cmd_row) + ADDR_ROW_SPAN;
                state_d = ST_FILL;
              end else begin
                err_d   = 1'b1;
              end
            end
          endcase
        end
      end

      ST_COPY: begin
        // Without the grant nothing new is issued and src holds; a read
        // already in flight still retires through pend_q this cycle.
        if (grant) begin
          pend_d  = 1'b1;
          waddr_d = src_q - ADDR_COLS;
          if (src_q == ADDR_LAST) begin
            state_d = ST_FLUSH;
          end else begin
            src_d = src_q + 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        // Retire the final copy write, then blank the freed bottom row
        ptr_d   = ADDR_LAST_ROW;
        end_d   = ADDR_LAST;
        state_d = ST_FILL;
      end

      ST_FILL: begin
        if (ptr_q == end_q) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any command in progress
  always_ff @(posedge vgaClk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      ptr_q   <= '0;
      end_q   <= '0;
      waddr_q <= '0;
      pend_q  <= 1'b0;
      char_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      waddr_q <= waddr_d;
      pend_q  <= pend_d;
      char_q  <= char_d;
      err_q   <= err_d;
    end
  end

  // Read-port mux and write-port drive; rst blocks writes in its own cycle
  always_comb begin
    ram_r_en   = disp_r_en;
    ram_r_addr = disp_r_addr;
    if (grant) begin
      ram_r_en   = 1'b1;
      ram_r_addr = src_q;
    end

    ram_w_en   = 1'b0;
    ram_w_addr = waddr_q;
    ram_w_data = ram_r_data;
    if (state_q == ST_FILL) begin
      ram_w_en   = !rst;
      ram_w_addr = ptr_q;
      ram_w_data = char_q;
    end else if ((state_q == ST_COPY) || (state_q == ST_FLUSH)) begin
      ram_w_en   = pend_q && !rst;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

`default_nettype wire
